// File: rtl/trees_dma_read_sequencer.sv
// Splits one beat-range read command into bounded DMA read bursts and streams the
// returned 64-bit beats to the consumer through a 2-entry in-order buffer.
module trees_dma_read_sequencer #(
   parameter int unsigned MAX_BURST_BEATS = 32'd4096,
   parameter logic [2:0]  DMA_SIZE        = 3'b011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_index,
   input  logic [31:0] cmd_length,
   output logic        dma_read_ctrl_valid,
   input  logic        dma_read_ctrl_ready,
   output logic [31:0] dma_read_ctrl_data_index,
   output logic [31:0] dma_read_ctrl_data_length,
   output logic [2:0]  dma_read_ctrl_data_size,
   output logic [5:0]  dma_read_ctrl_data_user,
   input  logic        dma_read_chnl_valid,
   output logic        dma_read_chnl_ready,
   input  logic [63:0] dma_read_chnl_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic [31:0] beat_count
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_XFER  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t      state_r, state_n;
   logic [31:0] cur_index_r, remaining_r, burst_left_r, beat_count_r;
   logic [63:0] mem_r [0:1];
   logic [1:0]  last_r;
   logic        wr_ptr_r, rd_ptr_r, full_r;
   logic [1:0]  count_r, count_n_s;
   logic        cmd_fire_s, ctrl_fire_s, push_s, pop_s, push_last_s;
   logic [31:0] req_len_s;

   function automatic logic [31:0] burst_len(input logic [31:0] rem);
      if (rem > 32'(MAX_BURST_BEATS)) begin
         return 32'(MAX_BURST_BEATS);
      end else begin
         return rem;
      end
   endfunction

   // Handshake qualifiers and FIFO occupancy update
   always_comb begin
      cmd_fire_s  = cmd_valid && (state_r == ST_IDLE);
      ctrl_fire_s = dma_read_ctrl_ready && (state_r == ST_REQ);
      push_s      = dma_read_chnl_valid && (state_r == ST_XFER) && !full_r;
      pop_s       = out_ready && (count_r != 2'd0);
      push_last_s = (remaining_r == 32'd1);
      req_len_s   = burst_len(remaining_r);
      count_n_s   = count_r;
      if (push_s && !pop_s) begin
         count_n_s = count_r + 2'd1;
      end else if (pop_s && !push_s) begin
         count_n_s = count_r - 2'd1;
      end else begin
         count_n_s = count_r;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               state_n = (cmd_length == 32'd0) ? ST_DONE : ST_REQ;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (ctrl_fire_s) begin
               state_n = ST_XFER;
            end else begin
               state_n = ST_REQ;
            end
         end
         ST_XFER: begin
            if (push_s && (burst_left_r == 32'd1)) begin
               state_n = push_last_s ? ST_DRAIN : ST_REQ;
            end else begin
               state_n = ST_XFER;
            end
         end
         ST_DRAIN: begin
            if (count_r == 2'd0) begin
               state_n = ST_DONE;
            end else begin
               state_n = ST_DRAIN;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      cmd_ready                 = 1'b0;
      dma_read_ctrl_valid       = 1'b0;
      dma_read_chnl_ready       = 1'b0;
      busy                      = 1'b1;
      done                      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_REQ:   dma_read_ctrl_valid = 1'b1;
         ST_XFER:  dma_read_chnl_ready = !full_r;
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: begin
            cmd_ready = 1'b0;
            busy      = 1'b0;
         end
      endcase
      // Request fields are zero outside REQ so reset and idle look identical
      if (state_r == ST_REQ) begin
         dma_read_ctrl_data_index  = cur_index_r;
         dma_read_ctrl_data_length = req_len_s;
      end else begin
         dma_read_ctrl_data_index  = 32'd0;
         dma_read_ctrl_data_length = 32'd0;
      end
      dma_read_ctrl_data_size = DMA_SIZE;
      dma_read_ctrl_data_user = 6'd0;
      out_valid               = (count_r != 2'd0);
      out_data                = mem_r[rd_ptr_r];
      out_last                = last_r[rd_ptr_r] && (count_r != 2'd0);
      beat_count              = beat_count_r;
   end

   // Command and burst counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_index_r  <= 32'd0;
         remaining_r  <= 32'd0;
         burst_left_r <= 32'd0;
      end else if (cmd_fire_s) begin
         cur_index_r <= cmd_index;
         remaining_r <= cmd_length;
      end else if (ctrl_fire_s) begin
         burst_left_r <= req_len_s;
         cur_index_r  <= cur_index_r + req_len_s;
      end else if (push_s) begin
         burst_left_r <= burst_left_r - 32'd1;
         remaining_r  <= remaining_r - 32'd1;
      end else begin
         cur_index_r <= cur_index_r;
      end
   end

   // Delivered-beat counter, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_count_r <= 32'd0;
      end else if (cmd_fire_s) begin
         beat_count_r <= 32'd0;
      end else if (pop_s && (beat_count_r != 32'hFFFF_FFFF)) begin
         beat_count_r <= beat_count_r + 32'd1;
      end else begin
         beat_count_r <= beat_count_r;
      end
   end

   // Two-entry output FIFO with last-beat tag per entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_r[0] <= 64'd0;
         mem_r[1] <= 64'd0;
         last_r   <= 2'b00;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
         full_r   <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r]  <= dma_read_chnl_data;
            last_r[wr_ptr_r] <= push_last_s;
            wr_ptr_r         <= ~wr_ptr_r;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r <= count_n_s;
         full_r  <= (count_n_s == 2'd2);
      end
   end

endmodule

// File: tb/tb_trees_dma_read_sequencer.sv
// Directed bench for trees_dma_read_sequencer with a one-request-at-a-time DMA model.
module tb_trees_dma_read_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_index, cmd_length;
   logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
   logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
   logic [2:0]  dma_read_ctrl_data_size;
   logic [5:0]  dma_read_ctrl_data_user;
   logic        dma_read_chnl_valid, dma_read_chnl_ready;
   logic [63:0] dma_read_chnl_data;
   logic        out_valid, out_ready, out_last;
   logic [63:0] out_data;
   logic        busy, done;
   logic [31:0] beat_count;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] req_idx_q [$];
   logic [31:0] req_len_q [$];
   logic [8:0]  req_attr_q [$];
   logic [63:0] out_q [$];
   logic        last_q [$];
   int          done_cnt, push_cnt, overlap, ctrl_seen, pending;
   logic [31:0] addr;

   trees_dma_read_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_length(cmd_length),
      .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
      .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
      .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
      .dma_read_ctrl_data_user(dma_read_ctrl_data_user),
      .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
      .dma_read_chnl_data(dma_read_chnl_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .beat_count(beat_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [191:0] outs_vec();
      return {16'd0, cmd_ready, busy, done, dma_read_ctrl_valid, dma_read_chnl_ready, out_valid,
              out_last, dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_ctrl_data_index,
              dma_read_ctrl_data_length, beat_count, out_data};
   endfunction

   function automatic logic [191:0] reset_vec();
      return {16'd0, 7'b1000000, 3'b011, 6'd0, 96'd0, 64'd0};
   endfunction

   task automatic clear_logs;
      req_idx_q.delete(); req_len_q.delete(); req_attr_q.delete();
      out_q.delete(); last_q.delete();
      done_cnt = 0; push_cnt = 0; ctrl_seen = 0;
   endtask

   task automatic start_cmd(input logic [31:0] idx, input logic [31:0] len);
      tick;
      cmd_valid = 1'b1; cmd_index = idx; cmd_length = len;
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit, input logic [31:0] exp_beats);
      for (int i = 0; i < limit; i++) begin
         tick; #2;
         if (done === 1'b1) break;
      end
      chk({tag, "_done_seen"}, done, 1);
      chk({tag, "_beat_count"}, beat_count, exp_beats);
      tick; #2;
      chk({tag, "_return_idle"}, {cmd_ready, done, busy}, 3'b100);
      chk({tag, "_done_once"}, done_cnt, 1);
   endtask

   task automatic check_stream(input string tag, input logic [31:0] base, input int len);
      int bad;
      logic [31:0] a;
      bad = 0;
      chk({tag, "_beats"}, out_q.size(), len);
      for (int i = 0; i < out_q.size(); i++) begin
         a = base + 32'(i);
         if (out_q[i] !== {32'hC0DE_5A5A, a}) bad++;
         if (last_q[i] !== (i == len - 1)) bad++;
      end
      chk({tag, "_order_last"}, bad, 0);
   endtask

   // DMA responder and passive recorder; samples 1 ns before each rising edge
   initial begin : dma_model
      pending = 0; addr = 32'd0; overlap = 0;
      dma_read_chnl_valid = 1'b0; dma_read_chnl_data = 64'd0;
      forever begin
         @(negedge clk);
         dma_read_chnl_valid = (pending > 0);
         dma_read_chnl_data  = {32'hC0DE_5A5A, addr};
         #4;
         if (!rst) begin
            pending = 0;
            dma_read_chnl_valid = 1'b0;
         end else begin
            if (dma_read_ctrl_valid) ctrl_seen++;
            if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
               if (pending != 0) overlap++;
               req_idx_q.push_back(dma_read_ctrl_data_index);
               req_len_q.push_back(dma_read_ctrl_data_length);
               req_attr_q.push_back({dma_read_ctrl_data_size, dma_read_ctrl_data_user});
               pending = int'(dma_read_ctrl_data_length);
               addr    = dma_read_ctrl_data_index;
            end
            if (dma_read_chnl_valid && dma_read_chnl_ready) begin
               pending--; addr++; push_cnt++;
            end
            if (out_valid && out_ready) begin
               out_q.push_back(out_data);
               last_q.push_back(out_last);
            end
            if (done) done_cnt++;
         end
      end
   end

   initial begin : stimulus
      int bad;
      rst = 1'b0; cmd_valid = 1'b0; cmd_index = 32'd0; cmd_length = 32'd0;
      dma_read_ctrl_ready = 1'b1; out_ready = 1'b1;
      clear_logs;
      tick; tick; #2;
      chk("reset_state", outs_vec(), reset_vec());
      tick;
      rst = 1'b1;

      // Single short burst
      clear_logs;
      start_cmd(32'd0, 32'd10);
      wait_done("t1", 100, 32'd10);
      chk("t1_req_count", req_idx_q.size(), 1);
      chk("t1_req0", {req_idx_q[0], req_len_q[0]}, {32'd0, 32'd10});
      chk("t1_size_user", req_attr_q[0], {3'b011, 6'd0});
      check_stream("t1", 32'd0, 10);

      // Long command split into three bursts
      clear_logs;
      start_cmd(32'd100, 32'd10000);
      wait_done("t2", 11000, 32'd10000);
      chk("t2_req_count", req_idx_q.size(), 3);
      chk("t2_req0", {req_idx_q[0], req_len_q[0]}, {32'd100, 32'd4096});
      chk("t2_req1", {req_idx_q[1], req_len_q[1]}, {32'd4196, 32'd4096});
      chk("t2_req2", {req_idx_q[2], req_len_q[2]}, {32'd8292, 32'd1808});
      check_stream("t2", 32'd100, 10000);

      // Zero-length command
      clear_logs;
      start_cmd(32'd5, 32'd0);
      #2;
      chk("t3_done_pulse", {done, cmd_ready}, 2'b10);
      tick; #2;
      chk("t3_ready_back", {done, cmd_ready}, 2'b01);
      tick;
      chk("t3_no_ctrl_valid", ctrl_seen, 0);
      chk("t3_done_once", done_cnt, 1);

      // Consumer backpressure for 20 cycles after the third push
      clear_logs;
      start_cmd(32'd200, 32'd16);
      for (int i = 0; i < 50 && push_cnt < 3; i++) tick;
      chk("t4_third_push_seen", push_cnt >= 3, 1);
      out_ready = 1'b0;
      repeat (10) tick;
      #2;
      chk("t4_chnl_stalled", {dma_read_chnl_ready, out_valid}, 2'b01);
      chk("t4_fifo_holds_two", push_cnt - out_q.size(), 2);
      repeat (10) tick;
      out_ready = 1'b1;
      wait_done("t4", 100, 32'd16);
      check_stream("t4", 32'd200, 16);

      // Request held off for 7 cycles; index wraps past 2^32
      clear_logs;
      dma_read_ctrl_ready = 1'b0;
      start_cmd(32'hFFFF_FFFE, 32'd4);
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) dma_read_ctrl_ready = 1'b1;
         #2;
         if ({dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length} !==
             {1'b1, 32'hFFFF_FFFE, 32'd4}) bad++;
         tick;
      end
      chk("t5_req_stable", bad, 0);
      #2;
      chk("t5_valid_drops", dma_read_ctrl_valid, 0);
      wait_done("t5", 100, 32'd4);
      chk("t5_req_count", req_idx_q.size(), 1);
      check_stream("t5", 32'hFFFF_FFFE, 4);

      // Asynchronous reset mid-transfer, then a fresh command
      clear_logs;
      start_cmd(32'd1000, 32'd64);
      for (int i = 0; i < 100 && push_cnt < 20; i++) tick;
      chk("t6_twenty_pushed", push_cnt >= 20, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_async_reset", outs_vec(), reset_vec());
      tick;
      rst = 1'b1;
      clear_logs;
      start_cmd(32'd50, 32'd4);
      wait_done("t6", 100, 32'd4);
      check_stream("t6", 32'd50, 4);
      chk("single_outstanding", overlap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
